// File: rtl/d_branch_unit.sv
// D-stage branch resolver with a direct-mapped 2-bit saturating-counter
// predictor (async read for F) and saturating branch/mispredict statistics.

module d_branch_unit_ctr #(
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic       taken,
  output logic [1:0] ctr
);
  logic [1:0] ctr_q, ctr_d;

  always_comb begin
    ctr_d = ctr_q;
    if (we) begin
      if (taken && ctr_q != 2'b11)       ctr_d = ctr_q + 2'd1;
      else if (!taken && ctr_q != 2'b00) ctr_d = ctr_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ctr_q <= INIT_STATE;
    else       ctr_q <= ctr_d;
  end

  assign ctr = ctr_q;
endmodule

module d_branch_unit #(
  parameter int         DATA_W     = 32,
  parameter int         IDX_BITS   = 6,
  parameter int         CNT_W      = 16,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       f_pc,
  output logic              f_pred_taken,
  input  logic [31:0]       d_pc,
  input  logic              d_valid,
  input  logic              d_stall,
  input  logic [DATA_W-1:0] d_rs,
  input  logic [DATA_W-1:0] d_rt,
  input  logic [2:0]        d_op,
  input  logic              d_pred_taken,
  output logic              d_taken,
  output logic              d_mispredict,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  mispred_cnt
);
  localparam int NUM_ENT = 1 << IDX_BITS;

  logic                           cond, is_op, is_br, upd;
  logic                           rs_neg, rs_zero;
  logic [IDX_BITS-1:0]            f_idx, d_idx;
  logic [NUM_ENT-1:0][1:0]        pht;
  logic [CNT_W-1:0]               branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]               mispred_cnt_q, mispred_cnt_d;

  assign rs_neg  = d_rs[DATA_W-1];
  assign rs_zero = (d_rs == '0);

  always_comb begin
    cond  = 1'b0;
    is_op = 1'b1;
    case (d_op)
      3'd1:    cond = (d_rs == d_rt);
      3'd2:    cond = (d_rs != d_rt);
      3'd3:    cond = rs_neg | rs_zero;
      3'd4:    cond = ~rs_neg & ~rs_zero;
      3'd5:    cond = rs_neg;
      3'd6:    cond = ~rs_neg;
      default: is_op = 1'b0;
    endcase
  end

  assign is_br        = d_valid & is_op;
  assign d_taken      = is_br & cond;
  assign d_mispredict = is_br & (d_taken != d_pred_taken);
  assign upd          = is_br & ~d_stall;

  assign f_idx = f_pc[IDX_BITS+1:2];
  assign d_idx = d_pc[IDX_BITS+1:2];

  // Read taps the flop outputs, so a same-index write shows up next cycle.
  generate
    for (genvar i = 0; i < NUM_ENT; i++) begin : g_ent
      d_branch_unit_ctr #(.INIT_STATE(INIT_STATE)) u_ctr (
        .clk   (clk),
        .reset (reset),
        .we    (upd && (d_idx == IDX_BITS'(i))),
        .taken (d_taken),
        .ctr   (pht[i])
      );
    end
  endgenerate

  assign f_pred_taken = pht[f_idx][1];

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd && !(&branch_cnt_q))                   branch_cnt_d  = branch_cnt_q + 1'b1;
    if (upd && d_mispredict && !(&mispred_cnt_q))  mispred_cnt_d = mispred_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{f_pc[31:IDX_BITS+2], f_pc[1:0], d_pc[31:IDX_BITS+2], d_pc[1:0]};
endmodule

// File: doc/d_branch_unit.md
Name: d_branch_unit

Overview:
- Successor to the D-stage branch comparator in the P7 MIPS pipeline.
- Resolves the extended branch set (beq/bne/blez/bgtz/bltz/bgez) over a parametrised data width.
- Adds a direct-mapped table of 2-bit saturating counters that gives a taken prediction to the F stage. The table is trained by D-stage resolutions.
- Flags mispredictions for the hazard/flush logic and keeps saturating branch and mispredict statistics counters.

Parameters:
DATA_W, 32, operand width compared in D
IDX_BITS, 6, log2 of predictor entries; table index = pc[IDX_BITS+1:2]
CNT_W, 16, width of statistics counters
INIT_STATE, 2'b01, counter value loaded by reset (weakly not-taken)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
f_pc  input  32  PC of the instruction in F
f_pred_taken  output  1  prediction for f_pc
d_pc  input  32  PC of the instruction in D
d_valid  input  1  D holds a real instruction (not a bubble)
d_stall  input  1  D is stalled this cycle
d_rs  input  DATA_W  forwarded rs value
d_rt  input  DATA_W  forwarded rt value
d_op  input  3  branch op code
d_pred_taken  input  1  prediction carried down from F with this instruction
d_taken  output  1  resolved branch outcome
d_mispredict  output  1  resolved outcome differs from prediction
branch_cnt  output  CNT_W  branches retired from D
mispred_cnt  output  CNT_W  mispredictions retired from D

Behaviour:
- d_op encoding:
  - 0 none
  - 1 beq: rs==rt
  - 2 bne: rs!=rt
  - 3 blez: signed rs<=0
  - 4 bgtz: signed rs>0
  - 5 bltz: signed rs<0
  - 6 bgez: signed rs>=0
  - 7 reserved, treated as none.
  - Sign comparisons use d_rs[DATA_W-1]. d_rt is ignored for ops 3-6.
- is_br = d_valid & (d_op in 1..6).
- d_taken = is_br & condition. Combinational, zero latency. It is 0 for bubbles, op 0 and op 7 regardless of operands.
- d_mispredict = is_br & (d_taken != d_pred_taken). Combinational. It may be asserted while d_stall=1; the consumer qualifies it.
- Predictor read:
  - f_pred_taken = table[f_pc[IDX_BITS+1:2]][1]. Combinational, no clock latency.
  - If the read index equals an index being written in the same cycle, the pre-update (old) value is returned.
- Predictor update (rising clk, when upd = is_br & ~d_stall) at index d_pc[IDX_BITS+1:2]:
  - taken: counter+1, saturating at 3.
  - not taken: counter-1, saturating at 0.
  - No update when d_stall=1, so a stalled branch trains exactly once, on the cycle it leaves D.
- Aliasing: PCs sharing index bits share a counter by design. No tag.
- Statistics, updated on the same upd condition:
  - branch_cnt += 1.
  - mispred_cnt += 1 when d_mispredict.
  - Both saturate at all-ones and never wrap.
- Reset (async, any time including mid-update):
  - All table entries = INIT_STATE.
  - branch_cnt = 0, mispred_cnt = 0.
  - f_pred_taken therefore reads INIT_STATE[1] (0 by default) immediately.
  - d_taken and d_mispredict stay purely combinational and are unaffected by reset.
- There is no other state. The table must be flops (2^IDX_BITS x 2), not RAM, because the read is asynchronous.

Test Plan:
- Compare coverage, DATA_W=32: d_valid=1, d_pred_taken=0.
  - rs=rt=0x5 with op1 -> d_taken=1.
  - op2 -> d_taken=0.
  - rs=0x80000000 with op3 -> 1, op5 -> 1, op4 -> 0, op6 -> 0.
  - rs=0 with op6 -> 1, op4 -> 0.
  - op7 or d_valid=0 -> d_taken=0 and d_mispredict=0.
- Counter training: reset, then f_pc=d_pc=0x3000.
  - Three taken beq resolutions (d_stall=0): f_pred_taken goes 0 -> 1 after the first (01->10), and the counter saturates at 11.
  - Four not-taken resolutions then return f_pred_taken to 0 after the second, saturating at 00.
- Stall: d_stall=1 for 5 cycles with a taken beq in D -> counter, branch_cnt and mispred_cnt unchanged. d_mispredict=1 throughout (pred=0). The first unstalled cycle increments each by exactly 1.
- Same-cycle read/write on the same index (f_pc=0x3004, d_pc=0x3104, IDX_BITS=6): f_pred_taken shows the old value in the update cycle and the new value the next cycle.
- Saturation: CNT_W=4, 20 mispredicted branches -> branch_cnt=mispred_cnt=4'hF, no wrap.
- Async reset mid-run: assert reset between clock edges after training -> counters read 0 and f_pred_taken=0 before the next clk edge. The table stays at INIT_STATE after reset is released.
